// File: rtl/bram_mem_pkg.sv
// Shared types and helpers for the pipelined data-memory BRAM.
package bram_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

  typedef struct packed {
    int unsigned lanes;
    int unsigned off_bits;
  } lane_geom_t;

  // Byte lanes per word and the number of byte-offset address bits below the word index.
  function automatic lane_geom_t lane_geom(int unsigned data_w);
    lane_geom_t g;
    g.lanes    = data_w / 8;
    g.off_bits = $clog2(g.lanes);
    return g;
  endfunction

endpackage

// File: rtl/bram_mem_pipe_if.sv
// Load/store-side access bus of the data-memory BRAM.
interface bram_mem_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic                  enb;
  logic [DATA_W/8-1:0]   web;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     dinb;
  logic                  rstb_busy;
  logic [DATA_W-1:0]     doutb;
  logic                  doutb_valid;
  logic                  addr_err;

  modport master (
    output enb, web, addrb, dinb,
    input  rstb_busy, doutb, doutb_valid, addr_err
  );

  modport slave (
    input  enb, web, addrb, dinb,
    output rstb_busy, doutb, doutb_valid, addr_err
  );

endinterface

// File: rtl/bram_mem_rdpipe.sv
// Read-return pipeline: RD_LAT register stages carrying {valid, err, data}.
module bram_mem_rdpipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clkb,
  input  logic              rstb,
  input  logic              acc_valid,
  input  logic              acc_err,
  input  logic [DATA_W-1:0] acc_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DATA_W-1:0] rd_data
);

  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0]             err_q;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_q;

  // Data stages only load on a valid so the output holds between strobes.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      vld_q <= '0;
      err_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= acc_valid;
      err_q[0] <= acc_valid & acc_err;
      if (acc_valid) dat_q[0] <= acc_data;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_valid = vld_q[RD_LAT-1];
  assign rd_err   = err_q[RD_LAT-1];
  assign rd_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/bram_mem_pipe.sv
// Single-port data-memory BRAM with byte lanes, hardware clear sequencer and
// a fixed-latency read-return pipeline with range checking.
module bram_mem_pipe
  import bram_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_MODE   = 0
) (
  input  logic            clkb,
  input  logic            rstb,
  bram_mem_pipe_if.slave  bus
);

  localparam lane_geom_t  Geom    = lane_geom(DATA_W);
  localparam int unsigned Lanes   = Geom.lanes;
  localparam int unsigned OffBits = Geom.off_bits;
  localparam int unsigned IdxW    = ADDR_W - OffBits;
  localparam int unsigned MemAw   = $clog2(MEM_DEPTH);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("bram_mem_pipe: RD_LAT must be 1 or 2");
  end

  if (OffBits > 0) begin : g_unused_lo
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.addrb[OffBits-1:0];
  end

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [MemAw-1:0]  ptr_q, ptr_d;
  logic              clr_we;
  logic              acc, acc_we, oob;
  logic [IdxW-1:0]   widx;
  logic [MemAw-1:0]  midx;
  logic [DATA_W-1:0] rd_word, merged, pipe_din;

  // Clear sequencer: state register, next-state, outputs.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (ptr_q == MemAw'(MEM_DEPTH - 1)) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + MemAw'(1);
        end
      end
      RUN:     ;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    bus.rstb_busy = (state_q == CLEAR);
    clr_we        = (state_q == CLEAR) && !rstb;
    acc           = bus.enb && (state_q == RUN) && !rstb;
  end

  // No truncation: any index at or beyond the depth is rejected outright.
  assign widx   = bus.addrb[ADDR_W-1:OffBits];
  assign oob    = (widx >= IdxW'(MEM_DEPTH));
  assign midx   = widx[MemAw-1:0];
  assign acc_we = acc && (|bus.web) && !oob;

  assign rd_word = mem[midx];

  always_comb begin
    merged = rd_word;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (bus.web[i]) merged[8*i +: 8] = bus.dinb[8*i +: 8];
    end
  end

  assign pipe_din = oob                     ? '0     :
                    (WR_MODE == WRITE_FIRST) ? merged : rd_word;

  always_ff @(posedge clkb) begin
    if (clr_we) begin
      mem[ptr_q] <= '0;
    end else if (acc_we) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (bus.web[i]) mem[midx][8*i +: 8] <= bus.dinb[8*i +: 8];
      end
    end
  end

  bram_mem_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clkb      (clkb),
    .rstb      (rstb),
    .acc_valid (acc),
    .acc_err   (oob),
    .acc_data  (pipe_din),
    .rd_valid  (bus.doutb_valid),
    .rd_err    (bus.addr_err),
    .rd_data   (bus.doutb)
  );

endmodule

// File: tb/tb_bram_mem_pipe.sv
// Directed bench: a read-first RD_LAT=1 and a write-first RD_LAT=2 instance share stimulus.
module tb_bram_mem_pipe;
  import bram_mem_pkg::*;

  localparam int NV = 14;

  typedef struct {
    string       name;
    logic [3:0]  web;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_rf;
    logic [31:0] exp_wf;
    logic        exp_err;
  } vec_t;

  logic clkb = 1'b0;
  logic rstb = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [NV];

  always #5 clkb = ~clkb;

  bram_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  bram_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  bram_mem_pipe #(
    .DATA_W(32), .MEM_DEPTH(4096), .ADDR_W(32), .RD_LAT(1), .WR_MODE(READ_FIRST)
  ) dut1 (
    .clkb (clkb),
    .rstb (rstb),
    .bus  (bus1)
  );

  bram_mem_pipe #(
    .DATA_W(32), .MEM_DEPTH(4096), .ADDR_W(32), .RD_LAT(2), .WR_MODE(WRITE_FIRST)
  ) dut2 (
    .clkb (clkb),
    .rstb (rstb),
    .bus  (bus2)
  );

  function automatic vec_t mk(input string n, input logic [3:0] we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rf,
                              input logic [31:0] wf, input logic e);
    vec_t v;
    v.name = n; v.web = we; v.addr = a; v.din = d; v.exp_rf = rf; v.exp_wf = wf; v.exp_err = e;
    return v;
  endfunction

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] din);
    bus1.enb = en; bus1.web = we; bus1.addrb = addr; bus1.dinb = din;
    bus2.enb = en; bus2.web = we; bus2.addrb = addr; bus2.dinb = din;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One isolated access; d1 strobes one cycle later, d2 two cycles later.
  task automatic run_vec(input vec_t v);
    @(negedge clkb);
    drive(1'b1, v.web, v.addr, v.din);
    @(negedge clkb);
    idle();
    chk({v.name, " d1 valid"}, bus1.doutb_valid, 1);
    chk({v.name, " d1 err"},   bus1.addr_err, v.exp_err);
    chk({v.name, " d1 data"},  bus1.doutb, v.exp_rf);
    chk({v.name, " d2 early"}, bus2.doutb_valid, 0);
    @(negedge clkb);
    chk({v.name, " d1 strobe end"}, bus1.doutb_valid, 0);
    chk({v.name, " d1 err end"},    bus1.addr_err, 0);
    chk({v.name, " d1 hold"},       bus1.doutb, v.exp_rf);
    chk({v.name, " d2 valid"},      bus2.doutb_valid, 1);
    chk({v.name, " d2 err"},        bus2.addr_err, v.exp_err);
    chk({v.name, " d2 data"},       bus2.doutb, v.exp_wf);
  endtask

  task automatic pulse_reset();
    @(negedge clkb);
    rstb = 1'b1;
    idle();
    @(negedge clkb);
    rstb = 1'b0;
  endtask

  // Called on the first negedge after rstb is released; counts busy cycles per DUT.
  task automatic count_clear(input string name, input bit poke);
    int c1, c2, strobes;
    c1 = 0; c2 = 0; strobes = 0;
    for (int g = 0; g < 5000; g++) begin
      if (!bus1.rstb_busy && !bus2.rstb_busy) break;
      c1 += int'(bus1.rstb_busy);
      c2 += int'(bus2.rstb_busy);
      strobes += int'(bus1.doutb_valid) + int'(bus2.doutb_valid);
      if (poke) drive(1'(g % 2), 4'(g % 16), 32'h40, 32'h77);
      @(negedge clkb);
    end
    idle();
    repeat (2) begin
      strobes += int'(bus1.doutb_valid) + int'(bus2.doutb_valid);
      @(negedge clkb);
    end
    chk({name, " d1 busy cycles"}, 32'(c1), 32'd4096);
    chk({name, " d2 busy cycles"}, 32'(c2), 32'd4096);
    chk({name, " strobes in clear"}, 32'(strobes), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk("wr full",       4'hF, 32'h10,       32'h11223344, 32'h0,        32'h11223344, 0);
    vecs[1]  = mk("wr lanes 0101", 4'h5, 32'h10,       32'hAABBCCDD, 32'h11223344, 32'h11BB33DD, 0);
    vecs[2]  = mk("rd lanes",      4'h0, 32'h10,       32'h0,        32'h11BB33DD, 32'h11BB33DD, 0);
    vecs[3]  = mk("rd unaligned",  4'h0, 32'h13,       32'h0,        32'h11BB33DD, 32'h11BB33DD, 0);
    vecs[4]  = mk("wr ones",       4'hF, 32'h20,       32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 0);
    vecs[5]  = mk("rdw lanes 0011",4'h3, 32'h20,       32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, 0);
    vecs[6]  = mk("rd after rdw",  4'h0, 32'h20,       32'h0,        32'hFFFF0000, 32'hFFFF0000, 0);
    vecs[7]  = mk("wr oob",        4'hF, 32'h4000,     32'h55,       32'h0,        32'h0,        1);
    vecs[8]  = mk("rd w0 no wrap", 4'h0, 32'h0,        32'h0,        32'h0,        32'h0,        0);
    vecs[9]  = mk("wr last",       4'hF, 32'h3FFC,     32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 0);
    vecs[10] = mk("rd last",       4'h0, 32'h3FFC,     32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0);
    vecs[11] = mk("rd oob high",   4'h0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        1);
    vecs[12] = mk("wr lane3",      4'h8, 32'h24,       32'h12345678, 32'h0,        32'h12000000, 0);
    vecs[13] = mk("rd lane3",      4'h0, 32'h24,       32'h0,        32'h12000000, 32'h12000000, 0);

    idle();
    rstb = 1'b1;
    repeat (2) @(negedge clkb);
    chk("reset d1 doutb", bus1.doutb, 0);
    chk("reset d2 doutb", bus2.doutb, 0);
    chk("reset d1 valid", bus1.doutb_valid, 0);
    chk("reset d2 valid", bus2.doutb_valid, 0);
    chk("reset d1 err",   bus1.addr_err, 0);
    chk("reset d2 err",   bus2.addr_err, 0);
    chk("reset d1 busy",  bus1.rstb_busy, 1);
    chk("reset d2 busy",  bus2.rstb_busy, 1);
    rstb = 1'b0;
    count_clear("init clear", 1'b0);

    // Preloaded word must be wiped by a single-cycle reset pulse.
    run_vec(mk("preload w5", 4'hF, 32'h14, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0));
    run_vec(mk("rd w5 before", 4'h0, 32'h14, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0));
    pulse_reset();
    count_clear("pulse clear", 1'b0);
    run_vec(mk("rd w5 cleared", 4'h0, 32'h14, 32'h0, 32'h0, 32'h0, 0));

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-to-back writes then back-to-back reads of words 0..3.
    for (int k = 0; k < 4; k++) begin
      @(negedge clkb);
      drive(1'b1, 4'hF, 32'(4 * k), 32'(k + 1));
    end
    @(negedge clkb);
    idle();
    repeat (3) @(negedge clkb);
    for (int c = 0; c < 7; c++) begin
      @(negedge clkb);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("burst d1 valid c%0d", c), bus1.doutb_valid, 1);
        chk($sformatf("burst d1 data c%0d", c), bus1.doutb, 32'(c));
      end else begin
        chk($sformatf("burst d1 idle c%0d", c), bus1.doutb_valid, 0);
      end
      if (c >= 2 && c <= 5) begin
        chk($sformatf("burst d2 valid c%0d", c), bus2.doutb_valid, 1);
        chk($sformatf("burst d2 data c%0d", c), bus2.doutb, 32'(c - 1));
      end else begin
        chk($sformatf("burst d2 idle c%0d", c), bus2.doutb_valid, 0);
      end
      if (c < 4) drive(1'b1, 4'h0, 32'(4 * c), 32'h0);
      else       idle();
    end

    // Write then read of the same word on the next cycle.
    @(negedge clkb);
    drive(1'b1, 4'hF, 32'h30, 32'hA5A5A5A5);
    @(negedge clkb);
    drive(1'b1, 4'h0, 32'h30, 32'h0);
    chk("raw d1 write old", bus1.doutb, 32'h0);
    @(negedge clkb);
    idle();
    chk("raw d1 valid", bus1.doutb_valid, 1);
    chk("raw d1 data",  bus1.doutb, 32'hA5A5A5A5);
    @(negedge clkb);
    chk("raw d2 valid", bus2.doutb_valid, 1);
    chk("raw d2 data",  bus2.doutb, 32'hA5A5A5A5);
    @(negedge clkb);

    // Reset while a read is in flight: d2's strobe must never appear.
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    @(negedge clkb);
    chk("midop d1 valid", bus1.doutb_valid, 1);
    chk("midop d1 data",  bus1.doutb, 32'h11BB33DD);
    rstb = 1'b1;
    idle();
    @(negedge clkb);
    chk("midop d2 flushed", bus2.doutb_valid, 0);
    chk("midop d1 valid end", bus1.doutb_valid, 0);
    chk("midop d1 doutb", bus1.doutb, 0);
    chk("midop d1 busy", bus1.rstb_busy, 1);
    chk("midop d2 busy", bus2.rstb_busy, 1);
    rstb = 1'b0;
    count_clear("midop clear", 1'b1);
    run_vec(mk("rd after midop", 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, 0));

    // Reset partway through a clear restarts the full sweep.
    pulse_reset();
    repeat (100) @(negedge clkb);
    pulse_reset();
    count_clear("restart clear", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
